// File: rtl/bht_pkg.sv
// Shared types and helpers for the BHT update sequencer: counter encoding,
// FSM state encoding and the 2-bit saturating counter step.
package bht_pkg;

  localparam int CNT_W = 2;

  localparam logic [CNT_W-1:0] CNT_SNT = 2'b00;
  localparam logic [CNT_W-1:0] CNT_WNT = 2'b01;
  localparam logic [CNT_W-1:0] CNT_WT  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ST  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cnt,
                                                input logic             taken);
    if (taken) return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Small power-of-two FIFO holding pending BHT updates as {idx, taken}.
// Caller qualifies push with !full and pop with !empty.
module bht_upd_fifo #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [IDX_W-1:0]           push_idx,
  input  logic                       push_taken,
  input  logic                       pop,
  output logic [IDX_W-1:0]           head_idx,
  output logic                       head_taken,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [IDX_W:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // NOTE: entry storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_idx, push_taken};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign {head_idx, head_taken} = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/bht_update_ctrl.sv
// Shares a single-port BHT between predict lookups and queued read-modify-write
// counter updates. Define BHT_FWD_EN to forward write data to a matching predict in WR.
module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter int IDX_W        = 10,
  parameter int UPD_DEPTH    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_valid,
  input  logic [IDX_W-1:0]  pred_idx,
  output logic              pred_ready,
  output logic [CNT_W-1:0]  pred_cnt,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  output logic              upd_ready,
  output logic [IDX_W-1:0]  bht_idx,
  output logic [CNT_W-1:0]  bht_wdata,
  output logic              bht_we,
  input  logic [CNT_W-1:0]  bht_rdata,
  output logic              busy
);

  localparam int WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int CNT_FW = $clog2(UPD_DEPTH) + 1;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] starve_q;
  logic [IDX_W-1:0]  idx_q;
  logic              taken_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              push, pop, fwd_hit;
  logic [IDX_W-1:0]  head_idx;
  logic              head_taken, fifo_full, fifo_empty;
  logic [CNT_FW-1:0] fifo_count;

  assign upd_ready = !fifo_full;
  assign push      = upd_valid && upd_ready;

  bht_upd_fifo #(.IDX_W(IDX_W), .DEPTH(UPD_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_idx   (upd_idx),
    .push_taken (upd_taken),
    .pop        (pop),
    .head_idx   (head_idx),
    .head_taken (head_taken),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pred_ready = 1'b0;
    bht_idx    = pred_idx;
    bht_we     = 1'b0;
    bht_wdata  = '0;
    pop        = 1'b0;
    fwd_hit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pred_ready = 1'b1;
        if (!fifo_empty) state_d = ST_RD;
      end
      ST_RD: begin
        if (pred_valid && (starve_q < WAIT_W'(STARVE_LIMIT))) begin
          pred_ready = 1'b1;
        end else begin
          bht_idx = head_idx;
          pop     = 1'b1;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        bht_we    = 1'b1;
        bht_idx   = idx_q;
        bht_wdata = sat_next(cnt_q, taken_q);
`ifdef BHT_FWD_EN
        fwd_hit    = pred_valid && (pred_idx == idx_q);
        pred_ready = fwd_hit;
`endif
        state_d = fifo_empty ? ST_IDLE : ST_RD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      idx_q    <= '0;
      taken_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        idx_q    <= head_idx;
        taken_q  <= head_taken;
        cnt_q    <= bht_rdata;
        starve_q <= '0;
      end else if (state_q == ST_RD && pred_ready) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  assign pred_cnt   = !pred_ready ? '0 : (fwd_hit ? bht_wdata : bht_rdata);
  assign pred_taken = pred_cnt[1];
  assign busy       = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Scoreboard bench for bht_update_ctrl: a behavioural BHT plus a shadow copy
// predicts every write, which is compared when the DUT strobes bht_we.
module tb_bht_update_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pred_valid;
  logic [9:0] pred_idx;
  logic       pred_ready;
  logic [1:0] pred_cnt;
  logic       pred_taken;
  logic       upd_valid;
  logic [9:0] upd_idx;
  logic       upd_taken;
  logic       upd_ready;
  logic [9:0] bht_idx;
  logic [1:0] bht_wdata;
  logic       bht_we;
  logic [1:0] bht_rdata;
  logic       busy;

  always #5 clk = ~clk;

  bht_update_ctrl #(.IDX_W(10), .UPD_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .pred_valid (pred_valid),
    .pred_idx   (pred_idx),
    .pred_ready (pred_ready),
    .pred_cnt   (pred_cnt),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready),
    .bht_idx    (bht_idx),
    .bht_wdata  (bht_wdata),
    .bht_we     (bht_we),
    .bht_rdata  (bht_rdata),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural BHT: combinational read, write on rising edge.
  logic [1:0] mem [1024];
  assign bht_rdata = mem[bht_idx];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 2'b00;
    mem[5] = 2'b01; mem[7] = 2'b11; mem[8] = 2'b00;
    mem[9] = 2'b01; mem[11] = 2'b01; mem[20] = 2'b10;
    forever begin
      @(posedge clk);
      if (!reset && bht_we) mem[bht_idx] <= bht_wdata;
    end
  end

  typedef struct {
    logic [9:0] idx;
    logic [1:0] data;
  } exp_t;

  exp_t       sbq [$];
  logic [1:0] sh  [1024];

  function automatic logic [1:0] model_sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  function automatic void model_push(input logic [9:0] idx, input logic t);
    exp_t e;
    sh[idx] = model_sat(sh[idx], t);
    e.idx   = idx;
    e.data  = sh[idx];
    sbq.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (bht_we) begin
      if (sbq.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("wr_idx", 32'(bht_idx), 32'(e.idx));
        check("wr_data", 32'(bht_wdata), 32'(e.data));
      end
    end
  end

  // Called at a negedge with upd_ready high; returns at the following negedge.
  task automatic push_upd(input logic [9:0] idx, input logic t);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = t;
    model_push(idx, t);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check(tag, 1, 0);
  endtask

  initial begin
    int acc, first_refuse, nwr;
    logic rdy;
    logic exp_pr [6];

    for (int i = 0; i < 1024; i++) sh[i] = 2'b00;
    sh[5] = 2'b01; sh[7] = 2'b11; sh[8] = 2'b00;
    sh[9] = 2'b01; sh[11] = 2'b01; sh[20] = 2'b10;

    reset = 1'b1; pred_valid = 1'b0; pred_idx = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_we", 32'(bht_we), 0);
    check("rst_idx", 32'(bht_idx), 0);
    check("rst_wdata", 32'(bht_wdata), 0);
    check("rst_upd_ready", 32'(upd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single update: write lands three edges after the push edge.
    push_upd(10'd5, 1'b1);
    check("t1_idle_busy", 32'(busy), 1);
    check("t1_idle_we", 32'(bht_we), 0);
    @(negedge clk);
    check("t1_rd_we", 32'(bht_we), 0);
    @(negedge clk);
    check("t1_wr_we", 32'(bht_we), 1);
    wait_idle("t1_idle_timeout");

    // Saturation at both ends.
    push_upd(10'd7, 1'b1);
    wait_idle("t2a_idle_timeout");
    push_upd(10'd8, 1'b0);
    wait_idle("t2b_idle_timeout");

    // Starvation: continuous predicts, one queued update.
    pred_valid = 1'b1; pred_idx = 10'd20;
    exp_pr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    push_upd(10'd3, 1'b1);
    check("t3_idle_cnt", 32'(pred_cnt), 2);
    check("t3_idle_taken", 32'(pred_taken), 1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("t3_pred_ready_%0d", k), 32'(pred_ready), 32'(exp_pr[k]));
    end
    check("t3_blocked_cnt", 32'(pred_cnt), 0);
    check("t3_wr_we", 32'(bht_we), 1);
    pred_valid = 1'b0;
    wait_idle("t3_idle_timeout");

    // Fill the FIFO while predicts slow the drain; the 5th push must wait.
    pred_valid = 1'b1; pred_idx = 10'd20;
    acc = 0; first_refuse = -1;
    upd_valid = 1'b1;
    for (int c = 0; c < 60 && acc < 5; c++) begin
      upd_idx   = 10'd100 + 10'(acc);
      upd_taken = acc[0];
      rdy = upd_ready;
      if (rdy) model_push(upd_idx, upd_taken);
      else if (first_refuse < 0) first_refuse = acc;
      @(posedge clk);
      if (rdy) acc++;
      @(negedge clk);
    end
    upd_valid = 1'b0;
    check("t4_accepted", 32'(acc), 5);
    check("t4_first_refuse", 32'(first_refuse), 4);
    pred_valid = 1'b0;
    wait_idle("t4_idle_timeout");

    // Back-to-back updates to one index; predict the same index in the 2nd WR.
    push_upd(10'd9, 1'b1);
    push_upd(10'd9, 1'b1);
    nwr = 0;
    for (int c = 0; c < 30 && nwr < 2; c++) begin
      if (bht_we) nwr++;
      if (nwr < 2) @(negedge clk);
    end
    check("t5_two_writes", 32'(nwr), 2);
    pred_valid = 1'b1; pred_idx = 10'd9;
    #1;
`ifdef BHT_FWD_EN
    check("t5_fwd_ready", 32'(pred_ready), 1);
    check("t5_fwd_cnt", 32'(pred_cnt), 3);
`else
    check("t5_wr_ready", 32'(pred_ready), 0);
    check("t5_wr_cnt", 32'(pred_cnt), 0);
`endif
    @(negedge clk);
    pred_valid = 1'b0; pred_idx = '0;
    wait_idle("t5_idle_timeout");

    // Reset while a write is on the bus.
    push_upd(10'd11, 1'b1);
    nwr = 0;
    for (int c = 0; c < 30 && nwr == 0; c++) begin
      if (bht_we) nwr = 1;
      else @(negedge clk);
    end
    check("t6_reached_wr", 32'(nwr), 1);
    reset = 1'b1;
    #1;
    check("t6_rst_we", 32'(bht_we), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_ready", 32'(upd_ready), 1);
    sbq.delete();
    sh[11] = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_bht_untouched", 32'(mem[11]), 1);
    check("t6_post_busy", 32'(busy), 0);

    check("sb_drain", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
